// File: rtl/mac_mul_seq_ctrl.sv
// Dot-product sequencer for a 4-lane MAC multiply block: accepts a job, streams
// N operand beats through a one-stage pipeline into a wide accumulator, returns the sum.
module mac_mul_seq_ctrl #(
  parameter int         MAC_CONF_WIDTH = 3,
  parameter int         MAC_MIN_WIDTH  = 8,
  parameter int         MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int         ACC_WIDTH      = 48,
  parameter int         LEN_WIDTH      = 16,
  // Encodings of cfg[1:0]; override to match the multiply block's mac_const.vh
  parameter logic [1:0] MAC_SINGLE     = 2'b00,
  parameter logic [1:0] MAC_DUAL       = 2'b01,
  parameter logic [1:0] MAC_QUAD       = 2'b10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [MAC_CONF_WIDTH-1:0]   start_cfg,
  input  logic [LEN_WIDTH-1:0]        start_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0]  in_a,
  input  logic [MAC_MIN_WIDTH-1:0]    in_b,
  output logic [4*MAC_MIN_WIDTH-1:0]  mul_a,
  output logic [MAC_MIN_WIDTH-1:0]    mul_b,
  output logic [MAC_CONF_WIDTH-1:0]   mul_cfg,
  input  logic [MAC_INT_WIDTH-1:0]    mul_c,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ACC_WIDTH-1:0]        res_data,
  output logic                        res_ovf,
  output logic                        res_err,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [MAC_CONF_WIDTH-1:0]   cfg_reg;
  logic [LEN_WIDTH-1:0]        cnt_reg;
  logic [ACC_WIDTH-1:0]        acc_reg;
  logic                        ovf_reg;
  logic                        err_reg;
  logic                        p1_v_reg;
  logic [4*MAC_MIN_WIDTH-1:0]  mul_a_reg;
  logic [MAC_MIN_WIDTH-1:0]    mul_b_reg;
  logic [MAC_CONF_WIDTH-1:0]   mul_cfg_reg;

  logic                        start_fire;
  logic                        beat_fire;
  logic                        start_cfg_ok;
  logic                        last_beat;
  logic [3:0]                  lane_en;
  logic [4*MAC_MIN_WIDTH-1:0]  a_masked;
  logic [ACC_WIDTH:0]          acc_sum;

  assign start_ready = (state_reg == IDLE);
  assign in_ready    = (state_reg == RUN);
  assign res_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);

  assign start_fire   = start_valid && start_ready;
  assign beat_fire    = in_valid && in_ready;
  assign last_beat    = (cnt_reg == LEN_WIDTH'(1));
  assign start_cfg_ok = (start_cfg[1:0] == MAC_SINGLE) ||
                        (start_cfg[1:0] == MAC_DUAL)   ||
                        (start_cfg[1:0] == MAC_QUAD);

  // Lanes the current config does not use are forced to zero toward the multiplier
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi == 0) begin : g_l0
        assign lane_en[gi] = 1'b1;
      end else if (gi == 1) begin : g_l1
        assign lane_en[gi] = (cfg_reg[1:0] == MAC_DUAL) || (cfg_reg[1:0] == MAC_QUAD);
      end else begin : g_lhi
        assign lane_en[gi] = (cfg_reg[1:0] == MAC_QUAD);
      end
      assign a_masked[gi*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] =
        lane_en[gi] ? in_a[gi*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] : '0;
    end
  endgenerate

  // Top bit of the widened sum is the carry out of the accumulator
  assign acc_sum = {1'b0, acc_reg} + (ACC_WIDTH+1)'(mul_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_fire) begin
          if (!start_cfg_ok || (start_len == '0)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (beat_fire && last_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reg     <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
      p1_v_reg    <= 1'b0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      mul_cfg_reg <= '0;
    end else if (start_fire) begin
      cfg_reg  <= start_cfg;
      cnt_reg  <= start_len;
      acc_reg  <= '0;
      ovf_reg  <= 1'b0;
      err_reg  <= !start_cfg_ok;
      p1_v_reg <= 1'b0;
    end else begin
      p1_v_reg <= beat_fire;
      if (beat_fire) begin
        mul_a_reg   <= a_masked;
        mul_b_reg   <= in_b;
        mul_cfg_reg <= cfg_reg;
        cnt_reg     <= cnt_reg - LEN_WIDTH'(1);
      end
      if (p1_v_reg) begin
        acc_reg <= acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH]) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign mul_a    = mul_a_reg;
  assign mul_b    = mul_b_reg;
  assign mul_cfg  = mul_cfg_reg;
  assign res_data = acc_reg;
  assign res_ovf  = ovf_reg;
  assign res_err  = err_reg;

endmodule

// File: doc/mac_mul_seq_ctrl.md
Name: mac_mul_seq_ctrl

Overview:
Sequencer that drives one 4-lane MAC multiply block (A0..A3 x B0, Single/Dual/Quad config) through a length-N dot-product job. It accepts a job descriptor, streams N operand beats into the multiply block over a valid/ready handshake, and accumulates the products into a wide accumulator. It returns the sum over a valid/ready result port. It sits between the tile's operand fetch logic and the multiply datapath, and owns the multiply block's inputs exclusively.

Parameters:
MAC_CONF_WIDTH, 3, config field width; encodings are the `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD macros from mac_const.vh, decoded on cfg[1:0]
MAC_MIN_WIDTH, 8, lane width
MAC_INT_WIDTH, 40 (5*MAC_MIN_WIDTH), multiply block result width
ACC_WIDTH, 48, accumulator width; must be >= MAC_INT_WIDTH
LEN_WIDTH, 16, job length field width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_valid  in  1  job descriptor valid
start_ready  out  1  controller can accept a job
start_cfg  in  MAC_CONF_WIDTH  job config
start_len  in  LEN_WIDTH  number of operand beats
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid&&in_ready
in_a  in  4*MAC_MIN_WIDTH  A3..A0 packed, A0 in LSBs
in_b  in  MAC_MIN_WIDTH  B0
mul_a  out  4*MAC_MIN_WIDTH  registered A3..A0 to multiply block
mul_b  out  MAC_MIN_WIDTH  registered B0 to multiply block
mul_cfg  out  MAC_CONF_WIDTH  registered config to multiply block
mul_c  in  MAC_INT_WIDTH  combinational product from multiply block
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid&&res_ready
res_data  out  ACC_WIDTH  accumulated sum
res_ovf  out  1  sticky: an accumulator carry-out occurred during the job
res_err  out  1  job rejected because of an illegal config
busy  out  1  state != IDLE

Behaviour:
- Reset values (rst high at a clock edge):
  - state=IDLE; all registers cleared.
  - res_valid=0, res_data=0, res_ovf=0, res_err=0, in_ready=0.
  - mul_a=0, mul_b=0, mul_cfg=0, busy=0.
  - rst mid-job aborts immediately. Beats in flight are discarded and no result is produced.
- States: IDLE, RUN, DRAIN, DONE.
- start_ready=(state==IDLE). in_ready=(state==RUN). res_valid=(state==DONE). All three are decoded from registered state.
- IDLE, on start_valid&&start_ready:
  - Latch cfg and len. Clear acc, ovf and err. Clear the stage-1 valid bit p1_v.
  - cfg[1:0] not one of SINGLE/DUAL/QUAD: go to DONE with res_data=0 and res_err=1. No beats are consumed.
  - len==0: go to DONE with res_data=0 and res_err=0.
  - Otherwise: go to RUN with remaining count cnt=len.
- RUN, on each accepted beat:
  - Register mul_a/mul_b/mul_cfg and set p1_v=1. Decrement cnt.
  - Unused lanes are zeroed: in Single, mul_a[31:8]=0; in Dual, mul_a[31:16]=0.
  - A cycle with no accepted beat sets p1_v=0. mul_* hold their values.
  - Beat accepted with cnt==1: go to DRAIN. in_ready drops the next cycle.
- Accumulate stage, every cycle p1_v==1: acc <= acc + zero-extended mul_c, modulo 2^ACC_WIDTH. A carry out of bit ACC_WIDTH-1 sets the sticky ovf.
- Latency: accumulate happens one edge after beat acceptance. A last beat accepted at edge k enters DRAIN at k, acc is final at k+1, and DONE/res_valid is asserted after k+1.
- DRAIN: lasts exactly one cycle (the final accumulate), then DONE.
- DONE:
  - res_data/res_ovf/res_err hold stable until res_valid&&res_ready.
  - On handshake: go to IDLE. start_ready=1 the following cycle; no combinational start-to-result bypass.
  - start_valid in DONE is ignored, because start_ready=0.
- Operands are unsigned. in_valid gaps are allowed and only stall the job.

Test Plan:
1. Single, len=3, (a0,b)=(2,5),(3,5),(4,5) back-to-back -> res_data=45, ovf=0, err=0; res_valid exactly 2 cycles after last beat accepted.
2. Dual, len=1, in_a=0x00000201, in_b=3 -> res_data=1539. Quad, len=2, in_a=0xFFFFFFFF, in_b=0xFF -> res_data=0x1FDFFFFFE02, mul_a upper lanes checked zeroed/passed per cfg.
3. Overflow: Quad, len=258, every beat in_a=0xFFFFFFFF, in_b=0xFF -> res_data=0x00FDFFFEFF02, res_ovf=1.
4. Backpressure: Single len=4 with in_valid low on alternating cycles; res_ready low for 3 cycles in DONE -> sum correct, res_data stable while stalled, in_ready=0 outside RUN.
5. Edge jobs: len=0 -> res_data=0, err=0, zero beats consumed. cfg[1:0] illegal with len=5 -> err=1, data=0, in_ready never asserted. Next legal job after each is correct (acc/ovf/err cleared).
6. Reset: rst pulsed in RUN after 2 of 5 beats -> next cycle state IDLE, all outputs at reset values. A fresh Single len=1 job (7x6) -> res_data=42.
